// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one instruction between EX and WB, waits for its
// data-SRAM response, extends load data, forwards to ID and hands off to WB.
// Responses belonging to instructions cancelled by a WB flush are counted and
// dropped so a later instruction only ever consumes its own response.
module mem_stage #(
  parameter int unsigned DISCARD_W = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        es_to_ms_valid,
  output logic        ms_allowin,
  input  logic [31:0] es_pc,
  input  logic        es_gr_we,
  input  logic [4:0]  es_dest,
  input  logic [31:0] es_alu_result,
  input  logic        es_mem_req,
  input  logic [2:0]  es_ld_op,
  input  logic        es_ex,
  input  logic [5:0]  es_ecode,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  input  logic        ws_allowin,
  input  logic        ws_flush_pipe,
  output logic        ms_to_ws_valid,
  output logic [31:0] ms_pc,
  output logic        ms_gr_we,
  output logic [4:0]  ms_dest,
  output logic [31:0] ms_final_result,
  output logic        ms_ex,
  output logic [5:0]  ms_ecode,
  output logic        ms_ex_block,
  output logic        ms_fwd_valid,
  output logic [4:0]  ms_fwd_dest,
  output logic [31:0] ms_fwd_data,
  output logic        ms_fwd_stall
);

  localparam logic [2:0] LD_NONE = 3'd0;
  localparam logic [2:0] LD_B    = 3'd1;
  localparam logic [2:0] LD_BU   = 3'd2;
  localparam logic [2:0] LD_H    = 3'd3;
  localparam logic [2:0] LD_HU   = 3'd4;
  localparam logic [2:0] LD_W    = 3'd5;
  localparam logic [DISCARD_W-1:0] DISCARD_MAX = {DISCARD_W{1'b1}};

  logic                 ms_valid;
  logic                 have_data;
  logic [31:0]          data_buf;
  logic [31:0]          alu_result_r;
  logic                 mem_req_r;
  logic [2:0]           ld_op_r;
  logic [DISCARD_W-1:0] discard_cnt;

  logic        data_ok_live;
  logic        ms_ready_go;
  logic        accept;
  logic        buffer_en;
  logic        discard_inc;
  logic        discard_dec;
  logic [31:0] raw;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  // Handshake: a response is live only once all stale responses are drained.
  always_comb begin
    data_ok_live = data_sram_data_ok && (discard_cnt == '0);
    ms_ready_go  = !mem_req_r || have_data || data_ok_live;
    accept       = es_to_ms_valid && ms_allowin && !ws_flush_pipe;
    buffer_en    = ms_valid && mem_req_r && !have_data && data_ok_live
                   && !ws_allowin && !ws_flush_pipe;
    discard_inc  = ws_flush_pipe && ms_valid && mem_req_r && !have_data
                   && !data_ok_live;
    discard_dec  = data_sram_data_ok && (discard_cnt != '0);
  end

  assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid && ms_ready_go && !ws_flush_pipe;

  // Load extraction from the buffered word if WB stalled us, else the live bus.
  always_comb begin
    raw     = have_data ? data_buf : data_sram_rdata;
    ld_byte = 8'(raw >> {alu_result_r[1:0], 3'b000});
    ld_half = alu_result_r[1] ? raw[31:16] : raw[15:0];
    ld_data = raw;
    case (ld_op_r)
      LD_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      LD_BU:   ld_data = {24'd0, ld_byte};
      LD_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      LD_HU:   ld_data = {16'd0, ld_half};
      LD_W:    ld_data = raw;
      default: ld_data = raw;
    endcase
  end

  assign ms_final_result = (ld_op_r != LD_NONE) ? ld_data : alu_result_r;
  assign ms_ex_block     = ms_valid && ms_ex;
  assign ms_fwd_valid    = ms_valid && ms_gr_we;
  assign ms_fwd_dest     = ms_dest;
  assign ms_fwd_data     = ms_final_result;
  assign ms_fwd_stall    = ms_valid && (ld_op_r != LD_NONE) && !have_data;

  // Stage valid and latched instruction fields; flush wins over accept.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ms_valid     <= 1'b0;
      have_data    <= 1'b0;
      data_buf     <= '0;
      ms_pc        <= '0;
      ms_gr_we     <= 1'b0;
      ms_dest      <= '0;
      alu_result_r <= '0;
      mem_req_r    <= 1'b0;
      ld_op_r      <= LD_NONE;
      ms_ex        <= 1'b0;
      ms_ecode     <= '0;
    end else begin
      if (ws_flush_pipe) begin
        ms_valid <= 1'b0;
      end else if (ms_allowin) begin
        ms_valid <= es_to_ms_valid;
      end
      if (accept) begin
        have_data    <= 1'b0;
        ms_pc        <= es_pc;
        ms_gr_we     <= es_gr_we;
        ms_dest      <= es_dest;
        alu_result_r <= es_alu_result;
        mem_req_r    <= es_mem_req;
        ld_op_r      <= es_ld_op;
        ms_ex        <= es_ex;
        ms_ecode     <= es_ecode;
      end else if (buffer_en) begin
        have_data <= 1'b1;
        data_buf  <= data_sram_rdata;
      end
    end
  end

  // Count responses still owed to flushed instructions (saturating).
  always_ff @(posedge clk) begin
    if (!resetn) begin
      discard_cnt <= '0;
    end else if (discard_inc && !discard_dec) begin
      if (discard_cnt != DISCARD_MAX) begin
        discard_cnt <= discard_cnt + DISCARD_W'(1);
      end
    end else if (discard_dec && !discard_inc) begin
      discard_cnt <= discard_cnt - DISCARD_W'(1);
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios with constant expectations, then a
// randomized run checked every cycle against a transaction-level model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        es_to_ms_valid;
  logic        ms_allowin;
  logic [31:0] es_pc;
  logic        es_gr_we;
  logic [4:0]  es_dest;
  logic [31:0] es_alu_result;
  logic        es_mem_req;
  logic [2:0]  es_ld_op;
  logic        es_ex;
  logic [5:0]  es_ecode;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        ws_allowin;
  logic        ws_flush_pipe;
  logic        ms_to_ws_valid;
  logic [31:0] ms_pc;
  logic        ms_gr_we;
  logic [4:0]  ms_dest;
  logic [31:0] ms_final_result;
  logic        ms_ex;
  logic [5:0]  ms_ecode;
  logic        ms_ex_block;
  logic        ms_fwd_valid;
  logic [4:0]  ms_fwd_dest;
  logic [31:0] ms_fwd_data;
  logic        ms_fwd_stall;

  mem_stage #(.DISCARD_W(2)) dut (
    .clk(clk), .resetn(resetn),
    .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
    .es_pc(es_pc), .es_gr_we(es_gr_we), .es_dest(es_dest),
    .es_alu_result(es_alu_result), .es_mem_req(es_mem_req),
    .es_ld_op(es_ld_op), .es_ex(es_ex), .es_ecode(es_ecode),
    .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .ws_allowin(ws_allowin), .ws_flush_pipe(ws_flush_pipe),
    .ms_to_ws_valid(ms_to_ws_valid), .ms_pc(ms_pc), .ms_gr_we(ms_gr_we),
    .ms_dest(ms_dest), .ms_final_result(ms_final_result), .ms_ex(ms_ex),
    .ms_ecode(ms_ecode), .ms_ex_block(ms_ex_block),
    .ms_fwd_valid(ms_fwd_valid), .ms_fwd_dest(ms_fwd_dest),
    .ms_fwd_data(ms_fwd_data), .ms_fwd_stall(ms_fwd_stall)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: the instruction held in MEM, whether its own response has been
  // captured, how many responses still belong to flushed instructions, and
  // how many responses the SRAM still owes in total.
  bit          m_v, m_got, m_we, m_req, m_ex;
  logic [31:0] m_pc, m_alu, m_data;
  logic [4:0]  m_dest;
  logic [5:0]  m_ecode;
  int          m_ld, m_stale, owed;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] load_ext(input int op, input logic [31:0] w,
                                           input int off);
    int unsigned b, h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * (off / 2))) & 32'hFFFF;
    case (op)
      1:       return 32'((b >= 128) ? b - 256 : b);
      2:       return 32'(b);
      3:       return 32'((h >= 32768) ? h - 65536 : h);
      4:       return 32'(h);
      default: return w;
    endcase
  endfunction

  // Compare all outputs with the model just before the edge, then advance.
  task automatic step();
    bit          mine, done, allow, acc;
    logic [31:0] word, res;
    int          n;
    #2;
    mine  = data_sram_data_ok && (m_stale == 0);
    done  = !m_req || m_got || mine;
    allow = !m_v || (done && ws_allowin);
    word  = m_got ? m_data : data_sram_rdata;
    res   = (m_ld != 0) ? load_ext(m_ld, word, int'(m_alu[1:0])) : m_alu;
    check_eq("allowin", 32'(ms_allowin), 32'(allow));
    check_eq("to_ws_valid", 32'(ms_to_ws_valid), 32'(m_v && done && !ws_flush_pipe));
    check_eq("pc", ms_pc, m_pc);
    check_eq("gr_we", 32'(ms_gr_we), 32'(m_we));
    check_eq("dest", 32'(ms_dest), 32'(m_dest));
    check_eq("ex", 32'(ms_ex), 32'(m_ex));
    check_eq("ecode", 32'(ms_ecode), 32'(m_ecode));
    check_eq("ex_block", 32'(ms_ex_block), 32'(m_v && m_ex));
    check_eq("fwd_valid", 32'(ms_fwd_valid), 32'(m_v && m_we));
    check_eq("fwd_dest", 32'(ms_fwd_dest), 32'(m_dest));
    check_eq("fwd_stall", 32'(ms_fwd_stall), 32'(m_v && (m_ld != 0) && !m_got));
    if (m_v) begin
      check_eq("final_result", ms_final_result, res);
      check_eq("fwd_data", ms_fwd_data, res);
    end
    acc = es_to_ms_valid && allow && !ws_flush_pipe;
    if (!resetn) begin
      m_v = 0; m_got = 0; m_we = 0; m_req = 0; m_ex = 0; m_pc = '0; m_alu = '0;
      m_data = '0; m_dest = '0; m_ecode = '0; m_ld = 0; m_stale = 0; owed = 0;
    end else begin
      if (data_sram_data_ok && owed > 0) owed--;
      if (acc && es_mem_req) owed++;
      n = m_stale;
      if (data_sram_data_ok && m_stale > 0) n--;
      if (ws_flush_pipe) begin
        if (m_v && m_req && !m_got && !mine) n++;
        m_v = 0;
      end else if (acc) begin
        m_v = 1; m_got = 0; m_pc = es_pc; m_we = es_gr_we; m_dest = es_dest;
        m_alu = es_alu_result; m_req = es_mem_req; m_ld = int'(es_ld_op);
        m_ex = es_ex; m_ecode = es_ecode;
      end else if (allow) begin
        m_v = 0;
      end else if (m_v && m_req && !m_got && mine) begin
        m_got = 1; m_data = data_sram_rdata;
      end
      m_stale = (n > 3) ? 3 : n;
    end
    @(posedge clk);
    #1;
  endtask

  // Present one instruction from EX for a single cycle.
  task automatic send(input logic [31:0] pc, input logic [4:0] dest,
                      input logic [31:0] alu, input logic req,
                      input logic [2:0] ld);
    es_to_ms_valid = 1'b1; es_pc = pc; es_gr_we = 1'b1; es_dest = dest;
    es_alu_result = alu; es_mem_req = req; es_ld_op = ld;
    es_ex = 1'b0; es_ecode = '0;
    step();
    es_to_ms_valid = 1'b0; es_mem_req = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; es_to_ms_valid = 1'b0; es_pc = '0; es_gr_we = 1'b0;
    es_dest = '0; es_alu_result = '0; es_mem_req = 1'b0; es_ld_op = '0;
    es_ex = 1'b0; es_ecode = '0; data_sram_data_ok = 1'b0; data_sram_rdata = '0;
    ws_allowin = 1'b1; ws_flush_pipe = 1'b0;
    m_v = 0; m_got = 0; m_we = 0; m_req = 0; m_ex = 0; m_pc = '0; m_alu = '0;
    m_data = '0; m_dest = '0; m_ecode = '0; m_ld = 0; m_stale = 0; owed = 0;
    @(posedge clk);
    #1;

    // Reset state: everything clear, empty stage accepts.
    check_eq("rst_to_ws_valid", 32'(ms_to_ws_valid), 32'd0);
    check_eq("rst_pc", ms_pc, 32'd0);
    check_eq("rst_result", ms_final_result, 32'd0);
    check_eq("rst_fwd_stall", 32'(ms_fwd_stall), 32'd0);
    check_eq("rst_allowin", 32'(ms_allowin), 32'd1);
    step();
    resetn = 1'b1;

    // Non-memory instruction leaves one cycle after entry.
    send(32'h1c00_0000, 5'd4, 32'h1234_5678, 1'b0, 3'd0);
    #1;
    check_eq("add_valid", 32'(ms_to_ws_valid), 32'd1);
    check_eq("add_result", ms_final_result, 32'h1234_5678);
    check_eq("add_dest", 32'(ms_dest), 32'd4);
    step();

    // ld.b at offset 3, response after three waiting cycles.
    send(32'h1c00_0004, 5'd5, 32'h1000_0003, 1'b1, 3'd1);
    repeat (3) begin
      #1;
      check_eq("ldb_stall", 32'(ms_fwd_stall), 32'd1);
      check_eq("ldb_wait", 32'(ms_to_ws_valid), 32'd0);
      step();
    end
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h80FF_0011;
    #1;
    check_eq("ldb_valid", 32'(ms_to_ws_valid), 32'd1);
    check_eq("ldb_result", ms_final_result, 32'hFFFF_FF80);
    step();
    data_sram_data_ok = 1'b0;

    // ld.hu at offset 2 with the same word.
    send(32'h1c00_0008, 5'd6, 32'h1000_0002, 1'b1, 3'd4);
    data_sram_data_ok = 1'b1;
    #1;
    check_eq("ldhu_result", ms_final_result, 32'h0000_80FF);
    step();
    data_sram_data_ok = 1'b0;

    // ld.w response while WB is stalled is held in the buffer.
    send(32'h1c00_000c, 5'd7, 32'h1000_0010, 1'b1, 3'd5);
    ws_allowin = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'hCAFE_BABE;
    #1;
    check_eq("ldw_live_result", ms_final_result, 32'hCAFE_BABE);
    step();
    data_sram_data_ok = 1'b0; data_sram_rdata = '0;
    repeat (2) begin
      #1;
      check_eq("ldw_hold_allowin", 32'(ms_allowin), 32'd0);
      check_eq("ldw_buf_result", ms_final_result, 32'hCAFE_BABE);
      step();
    end
    ws_allowin = 1'b1;
    #1;
    check_eq("ldw_hand_valid", 32'(ms_to_ws_valid), 32'd1);
    check_eq("ldw_hand_result", ms_final_result, 32'hCAFE_BABE);
    step();

    // Flush with a load outstanding: its response must be dropped later.
    send(32'h1c00_0010, 5'd8, 32'h1000_0020, 1'b1, 3'd5);
    ws_flush_pipe = 1'b1;
    #1;
    check_eq("flush_to_ws", 32'(ms_to_ws_valid), 32'd0);
    step();
    ws_flush_pipe = 1'b0;
    #1;
    check_eq("flush_gone", 32'(ms_fwd_stall), 32'd0);
    send(32'h1c00_0014, 5'd9, 32'h1000_0024, 1'b1, 3'd5);
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1111_1111;
    #1;
    check_eq("drop_valid", 32'(ms_to_ws_valid), 32'd0);
    check_eq("drop_stall", 32'(ms_fwd_stall), 32'd1);
    step();
    data_sram_data_ok = 1'b0;
    step();
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h2222_2222;
    #1;
    check_eq("keep_valid", 32'(ms_to_ws_valid), 32'd1);
    check_eq("keep_result", ms_final_result, 32'h2222_2222);
    step();
    data_sram_data_ok = 1'b0;

    // Flush in the same cycle as data_ok leaves nothing owed.
    send(32'h1c00_0018, 5'd10, 32'h1000_0028, 1'b1, 3'd5);
    ws_flush_pipe = 1'b1; data_sram_data_ok = 1'b1; data_sram_rdata = 32'hDEAD_BEEF;
    step();
    ws_flush_pipe = 1'b0; data_sram_data_ok = 1'b0;
    send(32'h1c00_001c, 5'd11, 32'h1000_002c, 1'b1, 3'd5);
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h3333_3333;
    #1;
    check_eq("nodisc_valid", 32'(ms_to_ws_valid), 32'd1);
    check_eq("nodisc_result", ms_final_result, 32'h3333_3333);
    step();
    data_sram_data_ok = 1'b0;

    // Flush coincident with EX valid blocks the accept.
    ws_flush_pipe = 1'b1;
    send(32'h1c00_0020, 5'd12, 32'h0000_0077, 1'b0, 3'd0);
    ws_flush_pipe = 1'b0;
    #1;
    check_eq("flushacc_valid", 32'(ms_to_ws_valid), 32'd0);
    check_eq("flushacc_fwd", 32'(ms_fwd_valid), 32'd0);
    step();

    // Reset during an outstanding load, then a normal add.
    send(32'h1c00_0024, 5'd13, 32'h1000_0030, 1'b1, 3'd5);
    step();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    #1;
    check_eq("rstw_valid", 32'(ms_to_ws_valid), 32'd0);
    check_eq("rstw_pc", ms_pc, 32'd0);
    check_eq("rstw_result", ms_final_result, 32'd0);
    check_eq("rstw_stall", 32'(ms_fwd_stall), 32'd0);
    send(32'h1c00_0028, 5'd14, 32'h0000_ABCD, 1'b0, 3'd0);
    #1;
    check_eq("post_valid", 32'(ms_to_ws_valid), 32'd1);
    check_eq("post_result", ms_final_result, 32'h0000_ABCD);
    step();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      int kind;
      resetn        = ($urandom_range(0, 499) != 0);
      ws_flush_pipe = ($urandom_range(0, 19) == 0);
      ws_allowin    = ($urandom_range(0, 3) != 0);
      es_to_ms_valid = ($urandom_range(0, 2) != 0);
      es_pc         = $urandom;
      es_gr_we      = 1'($urandom);
      es_dest       = 5'($urandom);
      es_alu_result = $urandom;
      es_ecode      = 6'($urandom);
      es_ex         = ($urandom_range(0, 15) == 0);
      kind          = int'($urandom_range(0, 2));
      es_mem_req    = 1'b0;
      es_ld_op      = 3'd0;
      if (es_to_ms_valid && !ws_flush_pipe && !es_ex && kind != 0) begin
        es_mem_req = 1'b1;
        es_ld_op   = (kind == 1) ? 3'($urandom_range(1, 5)) : 3'd0;
      end
      data_sram_data_ok = (owed > 0) && ($urandom_range(0, 2) == 0);
      data_sram_rdata   = $urandom;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
